// File: rtl/alu_result_fifo_if.sv
// Handshake bundle between the logic unit, the result FIFO and the write-back/condition stage.
interface alu_result_fifo_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_op;
  logic             out_zero;
  logic             out_neg;
  logic [CNT_W-1:0] count;
  logic             drop_err;

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, out_data, out_op, out_zero, out_neg, count, drop_err
  );

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_op, out_zero, out_neg, count, drop_err
  );
endinterface

// File: rtl/alu_result_fifo.sv
// Result FIFO behind the 16-bit logic unit: tags each word with its op code and
// zero/negative flags at write time and buffers DEPTH entries with valid/ready on both sides.
module alu_result_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_result_fifo_if.slave   bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             neg;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             drop;

  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;
  entry_t           wr_entry_c;
  entry_t           head_c;

  // Acceptance is decided from the registered count only, so a full FIFO
  // refuses a push even when the head is being popped in the same cycle.
  always_comb begin
    full_c           = (cnt == CNT_W'(DEPTH));
    empty_c          = (cnt == '0);
    push_c           = bus.in_valid && !full_c;
    pop_c            = bus.out_ready && !empty_c;
    wr_entry_c.op    = bus.in_op;
    wr_entry_c.data  = bus.in_data;
    wr_entry_c.zero  = (bus.in_data == '0);
    wr_entry_c.neg   = bus.in_data[WIDTH-1];
    head_c           = mem[rd_ptr];
  end

  // Storage and write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (push_c) begin
      mem[wr_ptr] <= wr_entry_c;
      wr_ptr      <= wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      cnt    <= '0;
      drop   <= 1'b0;
    end else begin
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (bus.in_valid && full_c) begin
        drop <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = !full_c;
  assign bus.out_valid = !empty_c;
  assign bus.out_data  = head_c.data;
  assign bus.out_op    = head_c.op;
  assign bus.out_zero  = head_c.zero;
  assign bus.out_neg   = head_c.neg;
  assign bus.count     = cnt;
  assign bus.drop_err  = drop;

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 16-bit logic unit: captures each result with its 2-bit op code, derives zero/negative flags, and buffers entries in a small FIFO.
- Decouples the combinational logic unit from the register write-back and condition logic that consume results.
- Valid/ready handshake on both sides.
- Sits between the logic unit output and the A/D register write-back / condition stage.

Parameters:
- WIDTH, 16, data width of a result word; must match the logic unit.
- DEPTH, 4, number of FIFO entries; power of two, 2..16.
- CNT_W, 3, width of the occupancy count; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents a result this cycle.
- in_ready  output  1  FIFO can accept; equals (count != DEPTH).
- in_op  input  2  op code {op1,op0} that produced in_data (00 AND, 01 OR, 10 XOR, 11 NOT X).
- in_data  input  WIDTH  logic unit output.
- out_valid  output  1  head entry available; equals (count != 0).
- out_ready  input  1  downstream consumes head this cycle.
- out_data  output  WIDTH  head entry data.
- out_op  output  2  head entry op code.
- out_zero  output  1  head data == 0.
- out_neg  output  1  head data[WIDTH-1].
- count  output  CNT_W  current occupancy, 0..DEPTH.
- drop_err  output  1  sticky flag: in_valid seen while in_ready low.

Behaviour:
- Reset is asynchronous and active-low (rst_n), with a single clock clk.
- While rst_n is low: wr_ptr=0, rd_ptr=0, count=0, drop_err=0, out_valid=0, in_ready=1.
- out_data, out_op, out_zero and out_neg read 0 after reset until the first write. Storage array is cleared on reset.
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push occurs on a rising edge when in_valid && in_ready.
  - Store {in_op, in_data, zero, neg} at wr_ptr.
  - zero = (in_data == 0); neg = in_data[WIDTH-1]. Flags are computed at write time, not at read time.
  - wr_ptr increments modulo DEPTH.
- Pop occurs on a rising edge when out_valid && out_ready; rd_ptr increments modulo DEPTH.
- Head outputs are driven combinationally from the entry at rd_ptr. Latency: a word pushed into an empty FIFO appears on out_* the next cycle (1-cycle latency). There is no same-cycle bypass.
- Count rules:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both take effect.
  - Simultaneous push and pop is legal when full. in_ready is derived from the registered count, so a push when full is not accepted even if out_ready is high.
- Pointer wrap-around is transparent. DEPTH consecutive pushes return wr_ptr to 0.
- Full (count==DEPTH): in_ready=0; the input is ignored.
  - If in_valid=1 in this state, drop_err is set and stays set until reset.
- Empty (count==0): out_valid=0; out_ready is ignored, with no pointer or count change.
- Output stability: out_* hold their values while out_valid && !out_ready.
- Upstream may drop in_valid at any time. The FIFO never requires in_valid to be held.

Test Plan:
1. Reset, push 0x00F0 with op=00 -> next cycle out_valid=1, out_data=0x00F0, out_op=00, out_zero=0, out_neg=0, count=1.
2. Push 0x0000 (op 10), then 0x8001 (op 11), with out_ready=0 -> count=2. First pop gives zero=1; second gives neg=1, out_op=11.
3. Push 5 words with DEPTH=4 and out_ready=0 -> in_ready=0 after the 4th, 5th word not stored, drop_err=1, count=4. Drain -> words 1..4 in order, count=0, out_valid=0.
4. Full FIFO, in_valid=1 and out_ready=1 for 6 cycles -> one pop per cycle, push accepted only on cycles where count<4 at the edge. Order preserved; pointers wrap past 3 correctly.
5. Steady stream with in_valid=out_ready=1 at count=1 -> count stays 1 and throughput is 1 word/cycle; 10 words emerge in order.
6. Assert rst_n low asynchronously between edges with count=3 -> count=0, out_valid=0, drop_err=0 immediately. After release, the first push appears 1 cycle later.
